alu_exec_unit: RTL and testbench

- Execute-stage ALU for the 64-bit LEGv8 datapath.
- Sits directly upstream of the execute-stage 8:1 result selector and uses the same 3-bit op encoding as that selector.
- Computes AND/OR/ADD/XOR in one cycle; performs logical shifts serially, 1 bit per cycle, to save area.
- Registers result and NZCV flags behind a valid/ready handshake.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_exec_unit_serial_shifter.sv | 41 ++++
 rtl/alu_exec_unit.sv | 127 ++++++++++++
 tb/tb_alu_exec_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the LEGv8 execute-stage ALU: op encoding, FSM states
// and the NZCV flag bundle.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_LSR);
  endfunction

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// Bit-serial logical shifter: one bit per cycle, counting down the shift amount.
// data_out is the value after the current cycle's shift, so the final step can be committed directly.
module serial_shifter #(
  parameter int N   = 64,
  parameter int SHW = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           shift_en,
  input  logic           dir,
  input  logic [SHW-1:0] shamt,
  input  logic [N-1:0]   data_in,
  output logic [N-1:0]   data_out,
  output logic           done
);

  logic [N-1:0]   shift_q;
  logic [SHW-1:0] count_q;
  logic           dir_q;

  // Direction is latched at load because op may change while shifting (dir=1 is right).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else if (load) begin
      shift_q <= data_in;
      count_q <= shamt;
      dir_q   <= dir;
    end else if (shift_en && (count_q != '0)) begin
      shift_q <= data_out;
      count_q <= count_q - SHW'(1);
    end
  end

  assign data_out = dir_q ? (shift_q >> 1) : (shift_q << 1);
  assign done     = shift_en && (count_q == SHW'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/XOR, serial LSL/LSR, with
// registered result and NZCV flags presented behind a valid/ready handshake.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int N   = 64,
  parameter int SHW = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [SHW-1:0] shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   result,
  output logic           flag_n,
  output logic           flag_z,
  output logic           flag_c,
  output logic           flag_v,
  output logic           busy
);

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic         accept;
  logic         start_shift;
  logic [N:0]   sum_ext;
  logic [N-1:0] alu_res;
  nzcv_t        alu_flags;
  logic [N-1:0] shift_data;
  logic         shift_done;
  logic [N-1:0] result_q;
  nzcv_t        flags_q;

  // Gated by reset so nothing is handed over while the unit is held in reset.
  assign in_ready    = reset && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift_op(op) && (shamt != '0);
  assign sum_ext     = {1'b0, a} + {1'b0, b};

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res     = sum_ext[N-1:0];
        alu_flags.c = sum_ext[N];
        alu_flags.v = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      OP_XOR: alu_res = a ^ b;
      OP_LSL,
      OP_LSR: alu_res = a;
      default: alu_res = '0;
    endcase
    alu_flags.n = alu_res[N-1];
    alu_flags.z = (alu_res == '0);
  end

  serial_shifter #(
    .N   (N),
    .SHW (SHW)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .load     (start_shift),
    .shift_en (state_q == ST_SHIFT),
    .dir      (op == OP_LSR),
    .shamt    (shamt),
    .data_in  (a),
    .data_out (shift_data),
    .done     (shift_done)
  );

  // An accept in HOLD is treated exactly like one from IDLE, giving bubble-free back-to-back results.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = start_shift ? ST_SHIFT : ST_HOLD;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_SHIFT: if (shift_done) state_d = ST_HOLD;
        ST_HOLD:  if (out_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept && !start_shift) begin
      result_q <= alu_res;
      flags_q  <= alu_flags;
    end else if (shift_done) begin
      result_q  <= shift_data;
      flags_q.n <= shift_data[N-1];
      flags_q.z <= (shift_data == '0);
      flags_q.c <= 1'b0;
      flags_q.v <= 1'b0;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_SHIFT);
  assign result    = result_q;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus random checks of alu_exec_unit against an arithmetic reference
// model: values, NZCV, latency, busy duration, handshake and reset abort.
module tb_alu_exec_unit;

  localparam int N   = 64;
  localparam int SHW = 6;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     op = 3'b000;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic [SHW-1:0] shamt = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N-1:0]   result;
  logic           flag_n, flag_z, flag_c, flag_v;
  logic           busy;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.N(N), .SHW(SHW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: returns {n,z,c,v,result}; overflow judged on the true signed sum.
  function automatic logic [67:0] model(input logic [2:0] mop, input logic [63:0] ma,
                                        input logic [63:0] mb, input logic [5:0] msh);
    logic [63:0]        r;
    logic [64:0]        full;
    logic signed [64:0] s;
    logic               c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: begin
        full = 65'(ma) + 65'(mb);
        s    = $signed(ma) + $signed(mb);
        r    = full[63:0];
        c    = full[64];
        v    = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
      end
      3'd3: r = ma ^ mb;
      3'd4: r = ma << msh;
      3'd5: r = ma >> msh;
      default: r = '0;
    endcase
    return {r[63], (r == 64'd0), c, v, r};
  endfunction

  // Issue one op from an idle/hold unit and check latency, busy span, value and flags; leaves result held.
  task automatic applyStimulus(input string tag, input logic [2:0] top, input logic [63:0] ta,
                               input logic [63:0] tb_, input logic [5:0] tsh);
    logic [67:0] exp;
    int guard, lat, busy_cnt, ready_in_shift, exp_lat;
    exp = model(top, ta, tb_, tsh);
    exp_lat = ((top == 3'd4 || top == 3'd5) && tsh != 0) ? int'(tsh) + 1 : 1;
    @(negedge clock);
    op = top; a = ta; b = tb_; shamt = tsh; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 0; busy_cnt = 0; ready_in_shift = 0;
    do begin
      @(negedge clock);
      lat++;
      if (busy) busy_cnt++;
      if (busy && in_ready) ready_in_shift++;
      if (busy && out_valid) ready_in_shift++;
    end while (!out_valid && lat < 200);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    checkOutput({tag, "_shift_handshake"}, 64'(ready_in_shift), 64'd0);
    checkOutput({tag, "_result"}, result, exp[63:0]);
    checkOutput({tag, "_nzcv"}, 64'({flag_n, flag_z, flag_c, flag_v}), 64'(exp[67:64]));
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [63:0] ra, rb;
    logic [5:0]  rsh;
    logic [63:0] held;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

    applyStimulus("add_5_7", 3'd2, 64'd5, 64'd7, 6'd0);
    checkOutput("add_5_7_value", result, 64'd12);
    releaseResult();
    checkOutput("release_out_valid", 64'(out_valid), 64'd0);

    applyStimulus("add_ovf", 3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
    checkOutput("add_ovf_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b1001);
    releaseResult();
    applyStimulus("add_carry", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
    checkOutput("add_carry_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0110);
    releaseResult();
    applyStimulus("op_110", 3'd6, 64'h1234, 64'h5678, 6'd0);
    checkOutput("op_110_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0100);
    releaseResult();

    applyStimulus("lsl_4", 3'd4, 64'd1, 64'd0, 6'd4);
    checkOutput("lsl_4_value", result, 64'h10);
    releaseResult();
    applyStimulus("lsr_63", 3'd5, 64'h8000_0000_0000_0000, 64'd0, 6'd63);
    checkOutput("lsr_63_value", result, 64'd1);
    releaseResult();
    applyStimulus("lsr_0", 3'd5, 64'hDEAD_BEEF_0000_0001, 64'd0, 6'd0);
    releaseResult();

    // Held result with back-to-back accept on release
    applyStimulus("and_hold", 3'd0, 64'hF0F0, 64'hFF00, 6'd0);
    held = result;
    repeat (3) begin
      @(negedge clock);
      checkOutput("hold_result", result, 64'hF000);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
    end
    checkOutput("hold_stable", result, held);
    op = 3'd3; a = 64'hF0F0; b = 64'hFF00; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    checkOutput("b2b_out_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_result", result, 64'h0FF0);
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput("b2b_drain", 64'(out_valid), 64'd0);

    // Reset in the middle of a shift
    op = 3'd4; a = 64'h3; shamt = 6'd10; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("mid_shift_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_result", result, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus("post_reset_add", 3'd2, 64'd2, 64'd2, 6'd0);
    checkOutput("post_reset_value", result, 64'd4);
    releaseResult();

    // Random operations
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (i % 5 == 0) rb = ~ra + 64'd1;
      rsh = 6'($urandom_range(0, 63));
      applyStimulus($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rsh);
      releaseResult();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
